// File: rtl/cache_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_arbiter_pkg
// Description : Shared state encodings, watchdog defaults and the request
//               record used by the cache arbiter and its request latch.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_arbiter_pkg;

  // Arbiter state encodings (2-bit, legacy-compatible constants)
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_BUSY_I = 2'b01;
  localparam logic [1:0] ST_BUSY_D = 2'b10;

  // Watchdog: default limit and counter width
  localparam int TIMEOUT_DEFAULT = 31;
  localparam int WD_W            = 5;

  // Round-robin pointer values: the port preferred when both are pending
  localparam logic PTR_I = 1'b0;
  localparam logic PTR_D = 1'b1;

  // One controller request as seen on the ctl_* lines
  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
    logic        rd;
    logic        wr;
  } req_t;

  // A data request is malformed when it asks for read and write together or
  // targets an odd (unaligned) address.
  function automatic logic d_req_bad(input logic rd, input logic wr, input logic addr0);
    return (rd | wr) & ((rd & wr) | addr0);
  endfunction

endpackage : cache_arbiter_pkg
`default_nettype wire

// File: rtl/cache_arbiter_req_latch.sv
`default_nettype none
// ============================================================================
// Module      : req_latch
// Description : Holds the granted request while the arbiter waits for the
//               controller, so ctl_* stay stable even if the requester moves.
// Revision    : 1.0 - initial release
// ============================================================================
module req_latch
  import cache_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  req_t req_i,
  output req_t req_o
);

  req_t req_q;

  // Capture the request on a grant that cannot complete immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q <= '0;
    end else if (load_i) begin
      req_q <= req_i;
    end
  end

  assign req_o = req_q;

endmodule : req_latch
`default_nettype wire

// File: rtl/cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_arbiter
// Description : Shares one cache controller between an instruction fetch
//               port and a data port. Round-robin when both are pending,
//               zero-latency pass-through on a controller hit, request
//               latching plus watchdog while waiting on a miss.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rd,
  input  logic [15:0] i_addr,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_data_in,
  input  logic        ctl_done,
  input  logic        ctl_stall,
  input  logic [15:0] ctl_data_out,
  output logic        ctl_rd,
  output logic        ctl_wr,
  output logic [15:0] ctl_addr,
  output logic [15:0] ctl_data_in,
  output logic        i_done,
  output logic        i_stall,
  output logic        d_done,
  output logic        d_stall,
  output logic [15:0] rd_data,
  output logic        err
);

  // Last BUSY cycle the watchdog tolerates: the counter starts at 0 in the
  // first BUSY cycle, so it holds TIMEOUT-1 in the TIMEOUT-th one.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [1:0]      state_q, state_d;
  logic            ptr_q, ptr_d;
  logic [WD_W-1:0] wd_q, wd_d;

  logic i_pend, d_pend, d_bad, d_ok;
  logic grant_i, grant_d, timeout, load;
  logic i_done_c, d_done_c, err_c;
  req_t live_req, held_req, ctl_req;

  // ctl_stall is informational only; completion is signalled by ctl_done.
  logic unused_stall;
  assign unused_stall = ctl_stall;

  assign i_pend = i_rd;
  assign d_pend = d_rd | d_wr;
  assign d_bad  = d_req_bad(d_rd, d_wr, d_addr[0]);
  assign d_ok   = d_pend & ~d_bad;

  // Grants only exist in IDLE; the pointer breaks ties.
  assign grant_i = (state_q == ST_IDLE) & i_pend & (~d_ok | (ptr_q == PTR_I));
  assign grant_d = (state_q == ST_IDLE) & d_ok & (~i_pend | (ptr_q == PTR_D));

  assign timeout = (state_q != ST_IDLE) & ~ctl_done & (wd_q == WD_LAST);

  // Select the grantee's live request for the zero-latency IDLE path.
  always_comb begin
    live_req = '0;
    if (grant_d) begin
      live_req = '{addr: d_addr, data: d_data_in, rd: d_rd, wr: d_wr};
    end else if (grant_i) begin
      live_req = '{addr: i_addr, data: 16'h0000, rd: 1'b1, wr: 1'b0};
    end
  end

  req_latch u_req_latch (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .req_i  (live_req),
    .req_o  (held_req)
  );

  // Arbitration FSM: next state, pointer, watchdog and per-cycle pulses.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    wd_d     = wd_q;
    load     = 1'b0;
    ctl_req  = '0;
    i_done_c = 1'b0;
    d_done_c = 1'b0;
    err_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ctl_req = live_req;
        // A malformed data request is answered locally, never forwarded.
        if (d_bad) begin
          err_c    = 1'b1;
          d_done_c = 1'b1;
        end
        if (grant_i | grant_d) begin
          if (ctl_done) begin
            i_done_c = i_done_c | grant_i;
            d_done_c = d_done_c | grant_d;
            ptr_d    = grant_i ? PTR_D : PTR_I;
          end else begin
            load    = 1'b1;
            wd_d    = '0;
            state_d = grant_i ? ST_BUSY_I : ST_BUSY_D;
          end
        end else if (ctl_done) begin
          // Completion with nothing outstanding is a controller protocol error.
          err_c = 1'b1;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        ctl_req = held_req;
        wd_d    = wd_q + 1'b1;
        if (ctl_done | timeout) begin
          i_done_c = (state_q == ST_BUSY_I);
          d_done_c = (state_q == ST_BUSY_D);
          err_c    = timeout;
          // A timed-out access still counts as served so the other port gets
          // its turn even if one requester keeps hanging the controller.
          ptr_d    = (state_q == ST_BUSY_I) ? PTR_D : PTR_I;
          wd_d     = '0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, pointer and watchdog registers; reset drops any in-flight access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= PTR_I;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
    end
  end

  // Outputs are forced low while reset is held, including the pass-through paths.
  assign ctl_rd      = rst & ctl_req.rd;
  assign ctl_wr      = rst & ctl_req.wr;
  assign ctl_addr    = rst ? ctl_req.addr : 16'h0000;
  assign ctl_data_in = rst ? ctl_req.data : 16'h0000;
  assign i_done      = rst & i_done_c;
  assign d_done      = rst & d_done_c;
  assign i_stall     = rst & i_pend & ~i_done_c;
  assign d_stall     = rst & d_pend & ~d_done_c;
  assign err         = rst & err_c;
  assign rd_data     = (rst & (i_done_c | d_done_c)) ? ctl_data_out : 16'h0000;

endmodule : cache_arbiter
`default_nettype wire

// File: tb/tb_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_arbiter
// Description : Self-checking bench for cache_arbiter: vector table, directed
//               multi-cycle sequences and randomized traffic against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_arbiter;

  localparam int TO = 31;

  logic        clk;
  logic        rst;
  logic        i_rd, d_rd, d_wr, ctl_done, ctl_stall;
  logic [15:0] i_addr, d_addr, d_data_in, ctl_data_out;
  logic        ctl_rd, ctl_wr, i_done, i_stall, d_done, d_stall, err;
  logic [15:0] ctl_addr, ctl_data_in, rd_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cache_arbiter #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rd         (i_rd),
    .i_addr       (i_addr),
    .d_rd         (d_rd),
    .d_wr         (d_wr),
    .d_addr       (d_addr),
    .d_data_in    (d_data_in),
    .ctl_done     (ctl_done),
    .ctl_stall    (ctl_stall),
    .ctl_data_out (ctl_data_out),
    .ctl_rd       (ctl_rd),
    .ctl_wr       (ctl_wr),
    .ctl_addr     (ctl_addr),
    .ctl_data_in  (ctl_data_in),
    .i_done       (i_done),
    .i_stall      (i_stall),
    .d_done       (d_done),
    .d_stall      (d_stall),
    .rd_data      (rd_data),
    .err          (err)
  );

  typedef struct packed {
    logic        ctl_rd;
    logic        ctl_wr;
    logic [15:0] ctl_addr;
    logic [15:0] ctl_data_in;
    logic        i_done;
    logic        i_stall;
    logic        d_done;
    logic        d_stall;
    logic [15:0] rd_data;
    logic        err;
  } out_t;

  out_t act;
  assign act = {ctl_rd, ctl_wr, ctl_addr, ctl_data_in, i_done, i_stall,
                d_done, d_stall, rd_data, err};

  int n_checks = 0;
  int n_errors = 0;

  function automatic out_t eo(input logic crd, input logic cwr, input logic [15:0] ca,
                              input logic [15:0] cdi, input logic idn, input logic ist,
                              input logic ddn, input logic dst, input logic [15:0] rdd,
                              input logic er);
    return {crd, cwr, ca, cdi, idn, ist, ddn, dst, rdd, er};
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("rd=%0b wr=%0b addr=%h wdat=%h idone=%0b istall=%0b ddone=%0b dstall=%0b rdata=%h err=%0b",
                     o.ctl_rd, o.ctl_wr, o.ctl_addr, o.ctl_data_in, o.i_done, o.i_stall,
                     o.d_done, o.d_stall, o.rd_data, o.err);
  endfunction

  task automatic check(input string name, input out_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got {%s} want {%s}", name, fmt(act), fmt(exp));
    end
  endtask

  task automatic drive(input logic ir, input logic [15:0] ia, input logic dr, input logic dw,
                       input logic [15:0] da, input logic [15:0] dd, input logic cd,
                       input logic [15:0] cdo);
    i_rd = ir; i_addr = ia; d_rd = dr; d_wr = dw; d_addr = da; d_data_in = dd;
    ctl_done = cd; ctl_data_out = cdo;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
    tick();
    rst = 1'b1;
  endtask

  // ---------------- reference model (transaction level) ----------------
  int          m_owner;   // 0 nobody, 1 fetch, 2 data
  int          m_next;    // port served first when both are pending
  int          m_waited;  // BUSY cycles already spent on the current access
  logic [15:0] m_addr, m_data;
  logic        m_rd, m_wr;

  task automatic model_reset();
    m_owner = 0; m_next = 1; m_waited = 0;
    m_addr = '0; m_data = '0; m_rd = 0; m_wr = 0;
  endtask

  task automatic model_cycle(output out_t e);
    logic dreq, dbad, dok, late, fire;
    int   who;
    e = '0;
    if (m_owner == 0) begin
      dreq = d_rd || d_wr;
      dbad = dreq && ((d_rd && d_wr) || d_addr[0]);
      dok  = dreq && !dbad;
      who  = 0;
      if (i_rd && dok) who = m_next;
      else if (i_rd)   who = 1;
      else if (dok)    who = 2;
      if (who == 1) {e.ctl_rd, e.ctl_wr, e.ctl_addr, e.ctl_data_in} = {1'b1, 1'b0, i_addr, 16'h0000};
      if (who == 2) {e.ctl_rd, e.ctl_wr, e.ctl_addr, e.ctl_data_in} = {d_rd, d_wr, d_addr, d_data_in};
      e.i_done = (who == 1) && ctl_done;
      e.d_done = ((who == 2) && ctl_done) || dbad;
      e.err    = dbad || ((who == 0) && ctl_done);
      if (who != 0) begin
        if (ctl_done) m_next = 3 - who;
        else begin
          m_owner = who; m_waited = 0;
          m_addr = e.ctl_addr; m_data = e.ctl_data_in; m_rd = e.ctl_rd; m_wr = e.ctl_wr;
        end
      end
    end else begin
      {e.ctl_rd, e.ctl_wr, e.ctl_addr, e.ctl_data_in} = {m_rd, m_wr, m_addr, m_data};
      late = !ctl_done && (m_waited + 1 >= TO);
      fire = ctl_done || late;
      e.i_done = fire && (m_owner == 1);
      e.d_done = fire && (m_owner == 2);
      e.err    = late;
      if (fire) begin
        m_next  = 3 - m_owner;
        m_owner = 0;
      end else begin
        m_waited++;
      end
    end
    e.rd_data = (e.i_done || e.d_done) ? ctl_data_out : 16'h0000;
    e.i_stall = i_rd && !e.i_done;
    e.d_stall = (d_rd || d_wr) && !e.d_done;
  endtask

  // ---------------- single-cycle vector table ----------------
  typedef struct {
    string       name;
    logic        ir;
    logic [15:0] ia;
    logic        dr;
    logic        dw;
    logic [15:0] da;
    logic [15:0] dd;
    logic        cd;
    logic [15:0] cdo;
    out_t        exp;
  } vec_t;

  localparam int NV = 10;
  vec_t vt[NV];

  initial begin : bench_timeout
    #1_000_000;
    $display("FAIL bench_timeout: simulation did not finish in time");
    $fatal(1, "bench time limit");
  end

  initial begin : main
    out_t        e;
    logic        ia_act, da_act;
    int          stuck;
    int          op;

    rst = 1'b0;
    ctl_stall = 1'b0;
    drive(0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 16'h0);

    vt[0] = '{"v_idle",       0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h7777,
              eo(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 0)};
    vt[1] = '{"v_i_hit",      1, 16'h0040, 0, 0, 16'h0000, 16'h0000, 1, 16'h1111,
              eo(1, 0, 16'h0040, 16'h0000, 1, 0, 0, 0, 16'h1111, 0)};
    vt[2] = '{"v_i_miss",     1, 16'h0080, 0, 0, 16'h0000, 16'h0000, 0, 16'h1111,
              eo(1, 0, 16'h0080, 16'h0000, 0, 1, 0, 0, 16'h0000, 0)};
    vt[3] = '{"v_d_unalign",  0, 16'h0000, 1, 0, 16'h0003, 16'h0000, 0, 16'h2222,
              eo(0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h2222, 1)};
    vt[4] = '{"v_d_rdwr",     0, 16'h0000, 1, 1, 16'h0010, 16'h0000, 0, 16'h3333,
              eo(0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h3333, 1)};
    vt[5] = '{"v_both_ptrI",  1, 16'h0500, 0, 1, 16'h0600, 16'h1111, 0, 16'h0000,
              eo(1, 0, 16'h0500, 16'h0000, 0, 1, 0, 1, 16'h0000, 0)};
    vt[6] = '{"v_stray_done", 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 16'h9999,
              eo(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 1)};
    vt[7] = '{"v_d_wr_hit",   0, 16'h0000, 0, 1, 16'h0100, 16'hABCD, 1, 16'h5555,
              eo(0, 1, 16'h0100, 16'hABCD, 0, 0, 1, 0, 16'h5555, 0)};
    vt[8] = '{"v_i_hit_dbad", 1, 16'h0300, 1, 0, 16'h0005, 16'h0000, 1, 16'h4444,
              eo(1, 0, 16'h0300, 16'h0000, 1, 0, 1, 0, 16'h4444, 1)};
    vt[9] = '{"v_d_rd_miss",  0, 16'h0000, 1, 0, 16'h0200, 16'h0000, 0, 16'h4444,
              eo(1, 0, 16'h0200, 16'h0000, 0, 0, 0, 1, 16'h0000, 0)};

    // Outputs stay low while reset is held, even with live requests.
    drive(1, 16'h0040, 1, 1, 16'h0003, 16'hFFFF, 1, 16'hFFFF);
    #3;
    check("reset_outputs", '0);

    for (int k = 0; k < NV; k++) begin
      do_reset();
      drive(vt[k].ir, vt[k].ia, vt[k].dr, vt[k].dw, vt[k].da, vt[k].dd, vt[k].cd, vt[k].cdo);
      #1;
      check(vt[k].name, vt[k].exp);
    end

    // Fetch hit completes in the grant cycle and leaves the arbiter idle.
    do_reset();
    drive(1, 16'h0040, 0, 0, 16'h0, 16'h0, 1, 16'hCAFE);
    #1 check("hit_i_done", eo(1, 0, 16'h0040, 16'h0000, 1, 0, 0, 0, 16'hCAFE, 0));
    tick();
    drive(0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
    #1 check("hit_stays_idle", '0);

    // Data write held through a 16-cycle miss; live inputs wander meanwhile.
    do_reset();
    drive(0, 16'h0, 0, 1, 16'h1234, 16'hBEEF, 0, 16'h0);
    #1 check("wr_grant", eo(0, 1, 16'h1234, 16'hBEEF, 0, 0, 0, 1, 16'h0000, 0));
    for (int k = 1; k <= 15; k++) begin
      tick();
      drive(0, 16'h0, 0, 1, 16'($urandom) & 16'hFFFE, 16'($urandom), 0, 16'h0);
      #1 check($sformatf("wr_hold_%0d", k), eo(0, 1, 16'h1234, 16'hBEEF, 0, 0, 0, 1, 16'h0000, 0));
    end
    tick();
    drive(0, 16'h0, 0, 1, 16'h0AA0, 16'h5A5A, 1, 16'h1357);
    #1 check("wr_done", eo(0, 1, 16'h1234, 16'hBEEF, 0, 0, 1, 0, 16'h1357, 0));
    tick();
    drive(0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
    #1 check("wr_back_idle", '0);

    // Both ports pending continuously: service alternates I, D, I, D.
    do_reset();
    for (int n = 0; n < 4; n++) begin
      logic        is_d;
      logic [15:0] ga;
      is_d = (n % 2) == 1;
      ga   = is_d ? 16'h0200 : 16'h0100;
      drive(1, 16'h0100, 1, 0, 16'h0200, 16'h0000, 0, 16'h0);
      #1 check($sformatf("rr_grant_%0d", n), eo(1, 0, ga, 16'h0000, 0, 1, 0, 1, 16'h0000, 0));
      tick();
      drive(1, 16'h0100, 1, 0, 16'h0200, 16'h0000, 1, 16'h5A00 + 16'(n));
      #1 check($sformatf("rr_done_%0d", n),
               eo(1, 0, ga, 16'h0000, !is_d, is_d, is_d, !is_d, 16'h5A00 + 16'(n), 0));
      tick();
    end

    // Watchdog: data read never completed, fires in the 31st BUSY cycle.
    do_reset();
    drive(0, 16'h0, 1, 0, 16'h0020, 16'h0, 0, 16'h0F0F);
    #1 check("wd_grant", eo(1, 0, 16'h0020, 16'h0000, 0, 0, 0, 1, 16'h0000, 0));
    for (int k = 1; k <= TO; k++) begin
      tick();
      #1;
      if (k < TO) check($sformatf("wd_wait_%0d", k), eo(1, 0, 16'h0020, 16'h0000, 0, 0, 0, 1, 16'h0000, 0));
      else        check("wd_fire", eo(1, 0, 16'h0020, 16'h0000, 0, 0, 1, 0, 16'h0F0F, 1));
    end
    tick();
    drive(0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 16'h0F0F);
    #1 check("wd_idle_after", '0);

    // Reset during BUSY_I: outputs drop at once, no done, pointer back to I.
    do_reset();
    drive(1, 16'h0011, 0, 0, 16'h0, 16'h0, 1, 16'h0);
    #1 check("rb_hit_i", eo(1, 0, 16'h0011, 16'h0000, 1, 0, 0, 0, 16'h0000, 0));
    tick();
    drive(1, 16'h0ABC, 0, 0, 16'h0, 16'h0, 0, 16'h0);
    #1 check("rb_grant_i", eo(1, 0, 16'h0ABC, 16'h0000, 0, 1, 0, 0, 16'h0000, 0));
    tick();
    #1 check("rb_busy_i", eo(1, 0, 16'h0ABC, 16'h0000, 0, 1, 0, 0, 16'h0000, 0));
    drive(1, 16'h0ABC, 0, 0, 16'h0, 16'h0, 1, 16'h6666);
    rst = 1'b0;
    #1 check("rb_reset_zero", '0);
    tick();
    #1 check("rb_reset_held", '0);
    rst = 1'b1;
    drive(1, 16'h0ABC, 1, 0, 16'h0DE0, 16'h0, 0, 16'h0);
    #1 check("rb_ptr_i", eo(1, 0, 16'h0ABC, 16'h0000, 0, 1, 0, 1, 16'h0000, 0));

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    ia_act = 0; da_act = 0; stuck = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!ia_act && $urandom_range(2) == 0) begin
        ia_act = 1;
        i_rd   = 1;
        i_addr = 16'($urandom);
      end else if (!ia_act) begin
        i_rd = 0;
      end
      if (!da_act && $urandom_range(2) == 0) begin
        da_act = 1;
        op = $urandom_range(9);
        d_addr = 16'($urandom) & 16'hFFFE;
        d_data_in = 16'h0000;
        if (op == 0) begin d_rd = 1; d_wr = 1; end
        else if (op == 1) begin d_rd = 1; d_wr = 0; d_addr[0] = 1'b1; end
        else if (op < 6) begin d_rd = 1; d_wr = 0; end
        else begin d_rd = 0; d_wr = 1; d_data_in = 16'($urandom); end
      end else if (!da_act) begin
        d_rd = 0; d_wr = 0;
      end
      if (stuck > 0) begin
        stuck--;
        ctl_done = 0;
      end else begin
        if ($urandom_range(199) == 0) stuck = 40;
        ctl_done = ($urandom_range(9) < 3);
      end
      ctl_data_out = 16'($urandom);
      #1;
      model_cycle(e);
      check($sformatf("rand_%0d", cyc), e);
      if (e.i_done) ia_act = 0;
      if (e.d_done) da_act = 0;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_cache_arbiter
`default_nettype wire

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 31, meaning the maximum BUSY cycles without ctl_done before the watchdog fires.
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- i_rd  in  1  instruction fetch request
- i_addr  in  16  fetch address
- d_rd  in  1  data read request
- d_wr  in  1  data write request
- d_addr  in  16  data address
- d_data_in  in  16  write data
- ctl_done  in  1  cache controller completion pulse
- ctl_stall  in  1  controller busy
- ctl_data_out  in  16  controller read data
- ctl_rd  out  1  read request to controller
- ctl_wr  out  1  write request to controller
- ctl_addr  out  16  address to controller
- ctl_data_in  out  16  write data to controller
- i_done  out  1  fetch complete
- i_stall  out  1  fetch waiting
- d_done  out  1  data access complete
- d_stall  out  1  data access waiting
- rd_data  out  16  read return data
- err  out  1  protocol error pulse

Function
REQ-003 SHALL arbitrate one shared cache controller between the fetch port (I) and the data port (D).
REQ-004 SHALL implement states IDLE, BUSY_I and BUSY_D.
REQ-005 SHALL treat a requester as pending when its rd/wr is high; requesters hold the request and operands stable until their done.
REQ-006 In IDLE, only one pending requester SHALL be granted; both pending SHALL grant the one not granted last (round-robin pointer, reset value I).
REQ-007 In IDLE, the grantee's request SHALL drive ctl_* combinationally in the same cycle, so a controller hit completes with zero added latency.
REQ-008 In IDLE, ctl_done in the grant cycle SHALL pulse the grantee's done and flip the pointer; the state stays IDLE.
REQ-009 In IDLE, a grant without ctl_done SHALL latch addr/data/rd/wr into a request register and move to BUSY_I or BUSY_D.
REQ-010 In BUSY_x, ctl_* SHALL be driven from the latched request, ignoring live requester inputs.
REQ-011 In BUSY_x, ctl_done SHALL pulse x_done for one cycle, flip the pointer and return to IDLE.
REQ-012 rd_data SHALL equal ctl_data_out whenever either done is high, else 0.
REQ-013 x_stall SHALL be high whenever x is pending and x_done is low.
REQ-014 d_rd and d_wr both high SHALL pulse err, leave D ungranted and raise d_done without any controller access.
REQ-015 d_addr[0]=1 (unaligned) SHALL pulse err, leave D ungranted and raise d_done without any controller access.
REQ-016 A 5-bit watchdog SHALL clear on entry to BUSY_x and increment each BUSY cycle.
REQ-017 Watchdog reaching TIMEOUT without ctl_done SHALL pulse err and x_done and return to IDLE.
REQ-018 ctl_done in IDLE with no grant SHALL pulse err and be otherwise ignored.
REQ-019 A requester deasserting mid-BUSY SHALL NOT abort the access; its done still pulses.

Reset
REQ-020 Asserting rst (low) SHALL immediately force IDLE, pointer=I, watchdog=0, latched request=0.
REQ-021 While rst is low, all outputs SHALL be 0.
REQ-022 Reset mid-BUSY SHALL drop the in-flight access with no done pulse.

Structure
REQ-023 A shared package SHALL hold the state encodings (IDLE=2'b00, BUSY_I=2'b01, BUSY_D=2'b10) and the TIMEOUT default.
REQ-024 The latched request (16b addr, 16b data, rd, wr) SHALL be one sub-module, req_latch, with a load enable.

Verification
REQ-025 Bench SHALL cover: i_rd only, i_addr=0x0040, ctl_done same cycle -> i_done=1 that cycle, ctl_addr=0x0040, state stays IDLE.
REQ-026 Bench SHALL cover: d_wr to 0x1234 with data 0xBEEF, ctl_done after 16 cycles -> ctl_addr/ctl_data_in held at 0x1234/0xBEEF throughout, d_stall=1 until d_done.
REQ-027 Bench SHALL cover: both ports pending from reset -> grant order I, D, I, D across four completions.
REQ-028 Bench SHALL cover: d_rd to 0x0003 -> err=1 and d_done=1 in that cycle, ctl_rd=0.
REQ-029 Bench SHALL cover: BUSY_D with no ctl_done for 31 cycles -> err and d_done pulse, IDLE next cycle.
REQ-030 Bench SHALL cover: rst low during BUSY_I -> outputs 0 immediately, no i_done, pointer=I after release.
